// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the nandgameplus register file and decoder.
package regfile_pkg;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_INC  = 2'b01,
    SP_DEC  = 2'b10,
    SP_RSVD = 2'b11
  } sp_op_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 4;

  // Reserved encoding behaves exactly like SP_NONE.
  function automatic logic sp_op_active(input sp_op_e op);
    return (op == SP_INC) || (op == SP_DEC);
  endfunction

endpackage

// File: rtl/regfile_sp_unit.sv
// Stack-pointer register: auto inc/dec with wrap detection; an explicit write
// overrides any concurrent SP op and suppresses the wrap pulses.
module regfile_sp_unit
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  sp_op_e            sp_op,
  output logic [DATA_W-1:0] sp_data,
  output logic              sp_ovf,
  output logic              sp_unf,
  output logic              sp_touch
);

  logic [DATA_W-1:0] sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  always_comb begin
    sp_d  = sp_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (wr_en) begin
      sp_d = wr_data;
    end else begin
      case (sp_op)
        SP_INC: begin
          sp_d  = sp_q + 1'b1;
          ovf_d = (sp_q == '1);
        end
        SP_DEC: begin
          sp_d  = sp_q - 1'b1;
          unf_d = (sp_q == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign sp_data  = sp_q;
  assign sp_ovf   = ovf_q;
  assign sp_unf   = unf_q;
  assign sp_touch = wr_en || sp_op_active(sp_op);

endmodule

// File: rtl/regfile_gen2.sv
// Parametrised register file: GPRs, SP (via regfile_sp_unit) and hard-wired ZR.
// Optional same-cycle write forwarding to read ports: REGFILE_WRITE_BYPASS_EN.
module regfile_gen2
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int SEL_W    = $clog2(NUM_REGS),
  localparam int SP_IDX   = NUM_REGS - 2,
  localparam int ZR_IDX   = NUM_REGS - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  rx_sel,
  input  logic [SEL_W-1:0]  ry_sel,
  input  logic [SEL_W-1:0]  t_sel,
  output logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] ry_data,
  output logic [DATA_W-1:0] t_data,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        sp_op,
  output logic [DATA_W-1:0] sp_data,
  output logic              sp_ovf,
  output logic              sp_unf,
  output logic              uninit_rd
);

  localparam int NUM_PORTS = 3;

  logic [DATA_W-1:0]    view     [NUM_REGS];
  logic [NUM_REGS-1:0]  vld;
  logic [SEL_W-1:0]     rd_sel   [NUM_PORTS];
  logic [DATA_W-1:0]    rd_val   [NUM_PORTS];
  logic [NUM_PORTS-1:0] rd_bad;
  logic                 wr_live;
  logic                 sp_wr;
  logic                 sp_touch;
  logic [DATA_W-1:0]    sp_val;
  logic                 sp_vld_q, sp_vld_d;
  logic                 uninit_q, uninit_d;

  assign wr_live = wr_en && (wr_sel != SEL_W'(ZR_IDX));
  assign sp_wr   = wr_live && (wr_sel == SEL_W'(SP_IDX));

  regfile_sp_unit #(
    .DATA_W(DATA_W)
  ) u_sp (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (sp_wr),
    .wr_data (wr_data),
    .sp_op   (sp_op_e'(sp_op)),
    .sp_data (sp_val),
    .sp_ovf  (sp_ovf),
    .sp_unf  (sp_unf),
    .sp_touch(sp_touch)
  );

  // view[] is the architectural register image seen by every read port.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == ZR_IDX) begin : g_zr
        assign view[gi] = '0;
        assign vld[gi]  = 1'b1;
      end else if (gi == SP_IDX) begin : g_sp
        assign view[gi] = sp_val;
        assign vld[gi]  = sp_vld_q;
      end else begin : g_gpr
        logic [DATA_W-1:0] r_q, r_d;
        logic              v_q, v_d;
        logic              we;

        assign we = wr_live && (wr_sel == SEL_W'(gi));

        always_comb begin
          r_d = r_q;
          v_d = v_q;
          if (we) begin
            r_d = wr_data;
            v_d = 1'b1;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q <= '0;
            v_q <= 1'b0;
          end else begin
            r_q <= r_d;
            v_q <= v_d;
          end
        end

        assign view[gi] = r_q;
        assign vld[gi]  = v_q;
      end
    end
  endgenerate

  assign rd_sel[0] = rx_sel;
  assign rd_sel[1] = ry_sel;
  assign rd_sel[2] = t_sel;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [DATA_W-1:0] val;
      logic              bad;

      always_comb begin
        val = view[rd_sel[gi]];
        bad = !vld[rd_sel[gi]];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forwarded data is by definition written, so it never flags uninit.
        if (rst_n && wr_live && (rd_sel[gi] == wr_sel)) begin
          val = wr_data;
          bad = 1'b0;
        end
`endif
      end

      assign rd_val[gi] = val;
      assign rd_bad[gi] = bad;
    end
  endgenerate

  assign rx_data = rd_val[0];
  assign ry_data = rd_val[1];
  assign t_data  = rd_val[2];

  always_comb begin
    sp_vld_d = sp_vld_q | sp_touch;
    uninit_d = uninit_q | (|rd_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_vld_q <= 1'b0;
      uninit_q <= 1'b0;
    end else begin
      sp_vld_q <= sp_vld_d;
      uninit_q <= uninit_d;
    end
  end

  assign sp_data   = sp_val;
  assign uninit_rd = uninit_q;

endmodule

// File: tb/tb_regfile_gen2.sv
// Directed self-checking bench for regfile_gen2 (default 16-bit, 4-register build).
module tb_regfile_gen2;

  localparam int DW = 16;
  localparam int SW = 2;
  localparam logic [SW-1:0] R_D  = 2'd0;
  localparam logic [SW-1:0] R_A  = 2'd1;
  localparam logic [SW-1:0] R_SP = 2'd2;
  localparam logic [SW-1:0] R_ZR = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] rx_sel, ry_sel, t_sel, wr_sel;
  logic [DW-1:0] rx_data, ry_data, t_data, wr_data, sp_data;
  logic          wr_en, sp_ovf, sp_unf, uninit_rd;
  logic [1:0]    sp_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_gen2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_sel   (rx_sel),
    .ry_sel   (ry_sel),
    .t_sel    (t_sel),
    .rx_data  (rx_data),
    .ry_data  (ry_data),
    .t_data   (t_data),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .sp_op    (sp_op),
    .sp_data  (sp_data),
    .sp_ovf   (sp_ovf),
    .sp_unf   (sp_unf),
    .uninit_rd(uninit_rd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_sel  = R_ZR;
    ry_sel  = R_ZR;
    t_sel   = R_ZR;
    wr_en   = 1'b0;
    wr_sel  = R_ZR;
    wr_data = '0;
    sp_op   = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rx_sel = R_D;
    ry_sel = R_A;
    t_sel  = R_SP;
    #2;
    total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx got=%h exp=0000", rx_data); end
    total++; if (ry_data !== 16'h0000) begin bad++; $display("FAIL reset_ry got=%h exp=0000", ry_data); end
    total++; if (t_data !== 16'h0000) begin bad++; $display("FAIL reset_t got=%h exp=0000", t_data); end
    total++; if (sp_data !== 16'h0000) begin bad++; $display("FAIL reset_sp got=%h exp=0000", sp_data); end
    total++; if ({sp_ovf, sp_unf} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {sp_ovf, sp_unf}); end
    step();
    total++; if (uninit_rd !== 1'b0) begin bad++; $display("FAIL reset_uninit got=%b exp=0", uninit_rd); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("reset: done");
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_sel = R_D; wr_data = 16'h1234;
    step();
    wr_sel = R_A; wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    rx_sel = R_D; ry_sel = R_A;
    #1;
    total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL wr_rd_d got=%h exp=1234", rx_data); end
    total++; if (ry_data !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_a got=%h exp=beef", ry_data); end
    step();
    total++; if (uninit_rd !== 1'b0) begin bad++; $display("FAIL wr_rd_uninit got=%b exp=0", uninit_rd); end
    idle_inputs();
    $display("write_read: D=%h A=%h", 16'h1234, 16'hBEEF);
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_sel = R_ZR; wr_data = 16'hFFFF;
    step();
    wr_en = 1'b0;
    rx_sel = R_ZR; ry_sel = R_ZR; t_sel = R_ZR;
    #1;
    total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL zr_rx got=%h exp=0000", rx_data); end
    total++; if (ry_data !== 16'h0000) begin bad++; $display("FAIL zr_ry got=%h exp=0000", ry_data); end
    total++; if (t_data !== 16'h0000) begin bad++; $display("FAIL zr_t got=%h exp=0000", t_data); end
    step();
    total++; if (uninit_rd !== 1'b0) begin bad++; $display("FAIL zr_uninit got=%b exp=0", uninit_rd); end
    idle_inputs();
    $display("zero_reg: write FFFF dropped");
  endtask

  task automatic test_sp_wrap();
    wr_en = 1'b1; wr_sel = R_SP; wr_data = 16'hFFFF;
    step();
    wr_en = 1'b0;
    total++; if (sp_data !== 16'hFFFF) begin bad++; $display("FAIL sp_load got=%h exp=ffff", sp_data); end
    sp_op = 2'b01;
    step();
    sp_op = 2'b00;
    total++; if (sp_data !== 16'h0000) begin bad++; $display("FAIL sp_inc_wrap got=%h exp=0000", sp_data); end
    total++; if (sp_ovf !== 1'b1) begin bad++; $display("FAIL sp_ovf_pulse got=%b exp=1", sp_ovf); end
    step();
    total++; if (sp_ovf !== 1'b0) begin bad++; $display("FAIL sp_ovf_end got=%b exp=0", sp_ovf); end
    sp_op = 2'b10;
    step();
    sp_op = 2'b00;
    total++; if (sp_data !== 16'hFFFF) begin bad++; $display("FAIL sp_dec_wrap got=%h exp=ffff", sp_data); end
    total++; if ({sp_unf, sp_ovf} !== 2'b10) begin bad++; $display("FAIL sp_unf_pulse got=%b exp=10", {sp_unf, sp_ovf}); end
    step();
    total++; if (sp_unf !== 1'b0) begin bad++; $display("FAIL sp_unf_end got=%b exp=0", sp_unf); end
    sp_op = 2'b11;
    step();
    sp_op = 2'b00;
    total++; if (sp_data !== 16'hFFFF) begin bad++; $display("FAIL sp_rsvd got=%h exp=ffff", sp_data); end
    $display("sp_wrap: inc/dec wrap checked");
  endtask

  task automatic test_sp_override();
    // SP is FFFF here, so an honoured INC would also raise sp_ovf.
    wr_en = 1'b1; wr_sel = R_SP; wr_data = 16'h0100; sp_op = 2'b01;
    step();
    wr_en = 1'b0; sp_op = 2'b00;
    total++; if (sp_data !== 16'h0100) begin bad++; $display("FAIL sp_override got=%h exp=0100", sp_data); end
    total++; if (sp_ovf !== 1'b0) begin bad++; $display("FAIL sp_override_ovf got=%b exp=0", sp_ovf); end
    wr_en = 1'b1; wr_sel = R_D; wr_data = 16'h5A5A; sp_op = 2'b10;
    step();
    wr_en = 1'b0; sp_op = 2'b00;
    rx_sel = R_D; t_sel = R_SP;
    #1;
    total++; if (sp_data !== 16'h00FF) begin bad++; $display("FAIL sp_dual_sp got=%h exp=00ff", sp_data); end
    total++; if (rx_data !== 16'h5A5A) begin bad++; $display("FAIL sp_dual_d got=%h exp=5a5a", rx_data); end
    total++; if (t_data !== 16'h00FF) begin bad++; $display("FAIL sp_read_t got=%h exp=00ff", t_data); end
    idle_inputs();
    $display("sp_override: write wins, dual write ok");
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_sel = R_D; wr_data = 16'h0055;
    step();
    wr_data = 16'h00AA; rx_sel = R_D;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    total++; if (rx_data !== 16'h00AA) begin bad++; $display("FAIL rdw_same got=%h exp=00aa", rx_data); end
`else
    total++; if (rx_data !== 16'h0055) begin bad++; $display("FAIL rdw_same got=%h exp=0055", rx_data); end
`endif
    step();
    wr_en = 1'b0;
    #1;
    total++; if (rx_data !== 16'h00AA) begin bad++; $display("FAIL rdw_next got=%h exp=00aa", rx_data); end
    idle_inputs();
    $display("back_to_back: read-during-write on D");
  endtask

  task automatic test_uninit();
    do_reset();
    rx_sel = R_A;
    #1;
    total++; if (uninit_rd !== 1'b0) begin bad++; $display("FAIL uninit_early got=%b exp=0", uninit_rd); end
    step();
    rx_sel = R_ZR;
    total++; if (uninit_rd !== 1'b1) begin bad++; $display("FAIL uninit_set got=%b exp=1", uninit_rd); end
    wr_en = 1'b1; wr_sel = R_A; wr_data = 16'h7777;
    step();
    step();
    total++; if (uninit_rd !== 1'b1) begin bad++; $display("FAIL uninit_sticky got=%b exp=1", uninit_rd); end
    // Reset lands mid-cycle while a write to D is pending.
    wr_sel = R_D; wr_data = 16'h1111; rx_sel = R_A; ry_sel = R_D;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (uninit_rd !== 1'b0) begin bad++; $display("FAIL uninit_async_clr got=%b exp=0", uninit_rd); end
    total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL async_rst_a got=%h exp=0000", rx_data); end
    step();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    wr_en = 1'b1; wr_sel = R_SP; wr_data = 16'h0000;
    ry_sel = R_D;
    #1;
    total++; if (ry_data !== 16'h0000) begin bad++; $display("FAIL rst_write_lost got=%h exp=0000", ry_data); end
    idle_inputs();
    $display("uninit: sticky flag and async reset checked");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_sp_wrap();
    test_sp_override();
    test_back_to_back();
    test_uninit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_gen2.md
Name: regfile_gen2

Overview:
Parametrised general-purpose register file for the nandgameplus core, successor to the fixed 4-entry D/A/SP/ZR file.
- Configurable data width and register count; fixed hard-wired zero register; dedicated stack-pointer register with auto increment/decrement.
- Three combinational read ports (rx, ry, t) and one synchronous write port.
- Sits between instruction decode and the ALU; write-back arrives from the ALU result path.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 4, number of architectural registers including ZR; must be power of two, >=4
SEL_W, $clog2(NUM_REGS), selector width (derived, not overridden)
SP_IDX, NUM_REGS-2, index of the stack-pointer register
ZR_IDX, NUM_REGS-1, index of the hard-wired zero register

Ports:
clk  input  1  single core clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
rx_sel  input  SEL_W  read port X select
ry_sel  input  SEL_W  read port Y select
t_sel  input  SEL_W  read port T select
rx_data  output  DATA_W  contents of register rx_sel
ry_data  output  DATA_W  contents of register ry_sel
t_data  output  DATA_W  contents of register t_sel
wr_en  input  1  write strobe
wr_sel  input  SEL_W  write target
wr_data  input  DATA_W  write value
sp_op  input  2  00 none, 01 increment, 10 decrement, 11 reserved (treated as none)
sp_data  output  DATA_W  current SP value (combinational from SP register)
sp_ovf  output  1  one-cycle pulse: increment wrapped max->0
sp_unf  output  1  one-cycle pulse: decrement wrapped 0->max
uninit_rd  output  1  sticky: some non-ZR register was read before ever being written

Behaviour:
- Reset (rst_n low, async): all registers 0; valid bits cleared; sp_ovf=0, sp_unf=0, uninit_rd=0. Reads during reset return 0.
- Reads: combinational, zero latency. Reading ZR_IDX always returns 0. Read of an index >= NUM_REGS cannot occur (power-of-two rule).
- Write: on rising clk with wr_en=1 and wr_sel != ZR_IDX, reg[wr_sel] <= wr_data; its valid bit is set. Writes to ZR are silently dropped.
- Read-during-write (no bypass): read ports return the old value in the write cycle; the new value is visible the next cycle.
- SP op: increment/decrement modulo 2^DATA_W, taking effect on the next edge; the SP valid bit is set.
  - Increment from all-ones gives 0 and pulses sp_ovf for exactly one cycle (registered).
  - Decrement from 0 gives all-ones and pulses sp_unf for exactly one cycle.
- Simultaneous wr_en to SP_IDX and sp_op != 00: the explicit write wins, sp_op is ignored, and no ovf/unf pulse occurs.
- wr_en to another register with sp_op != 00: both take effect in the same edge.
- uninit_rd:
  - Set on the edge after any cycle in which an active read selects a non-ZR register whose valid bit is 0.
  - "Active" means the rx, ry and t ports are all always active; stalls are the decoder's concern.
  - Cleared only by reset.
- Reset asserted mid-write: the write is lost and all state returns to reset values immediately.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined: each read port whose select equals wr_sel while wr_en=1 and wr_sel != ZR_IDX returns wr_data in the same cycle. An SP read with sp_op active and no SP write still returns the old SP value, since SP ops are not bypassed. A bypassed read counts as valid for uninit_rd.
- Undefined: no forwarding; read-during-write returns the old value as described above.

Decomposition:
- Shared package regfile_pkg: sp_op_e enum (SP_NONE, SP_INC, SP_DEC, SP_RSVD) and the default DATA_W/NUM_REGS localparams shared with the decoder.
- One natural sub-module, regfile_sp_unit: holds the SP register, inc/dec/wrap logic, write-override priority and the ovf/unf pulse flops.
- Storage array, read muxes and valid bits stay in the top.

Test Plan:
- Reset, then write D(0)=0x1234 and A(1)=0xBEEF and read both on rx/ry -> next cycle rx_data=0x1234, ry_data=0xBEEF, uninit_rd=0.
- Write 0xFFFF to ZR_IDX, then read ZR on all three ports -> all read 0x0000.
- Write SP=0xFFFF, then sp_op=INC -> sp_data=0x0000 and sp_ovf high for exactly one cycle. Then sp_op=DEC -> sp_data=0xFFFF and sp_unf pulses once.
- Same cycle: wr_en to SP with wr_data=0x0100 and sp_op=INC -> sp_data=0x0100, no ovf pulse.
- After reset, read A without writing it -> uninit_rd=1 from the next cycle and stays 1 across later writes. Assert rst_n=0 asynchronously mid-cycle -> uninit_rd=0 and all reads 0 immediately.
- Same-cycle read/write of D with wr_data=0x00AA, old value 0x0055:
  - with REGFILE_WRITE_BYPASS_EN, rx_data=0x00AA in that cycle;
  - without it, rx_data=0x0055, then 0x00AA the following cycle.
